// File: rtl/vpg_pkg.sv
// rtl/vpg_pkg.sv - shared types, mode codes and timing table for the VPG mode sequencer
package vpg_pkg;

    localparam int unsigned TIMING_W = 12;
    localparam int unsigned MODE_W   = 4;

    // Mode codes as issued by the push-button mode selector
    localparam logic [MODE_W-1:0] MODE_640X480   = 4'd0;
    localparam logic [MODE_W-1:0] MODE_720X480   = 4'd1;
    localparam logic [MODE_W-1:0] MODE_1024X768  = 4'd2;
    localparam logic [MODE_W-1:0] MODE_1280X1024 = 4'd3;
    localparam logic [MODE_W-1:0] MODE_1920X1080 = 4'd4;
    localparam logic [MODE_W-1:0] MODE_1600X1200 = 4'd5;
    localparam logic [MODE_W-1:0] MODE_LAST      = MODE_1600X1200;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    typedef struct packed {
        logic [TIMING_W-1:0] h_total;
        logic [TIMING_W-1:0] h_sync;
        logic [TIMING_W-1:0] h_bp;
        logic [TIMING_W-1:0] h_act;
        logic [TIMING_W-1:0] v_total;
        logic [TIMING_W-1:0] v_sync;
        logic [TIMING_W-1:0] v_bp;
        logic [TIMING_W-1:0] v_act;
    } timing_t;

    function automatic logic mode_is_valid(input logic [MODE_W-1:0] code);
        return (code <= MODE_LAST);
    endfunction

    // Invalid codes fall back to the safe 640x480 mode
    function automatic logic [MODE_W-1:0] mode_clamp(input logic [MODE_W-1:0] code);
        return mode_is_valid(code) ? code : MODE_640X480;
    endfunction

    function automatic timing_t mode_timing(input logic [MODE_W-1:0] code);
        timing_t t;
        case (code)
            MODE_720X480:   t = '{12'd858,  12'd62,  12'd60,  12'd720,
                                  12'd525,  12'd6,   12'd30,  12'd480};
            MODE_1024X768:  t = '{12'd1344, 12'd136, 12'd160, 12'd1024,
                                  12'd806,  12'd6,   12'd29,  12'd768};
            MODE_1280X1024: t = '{12'd1688, 12'd112, 12'd248, 12'd1280,
                                  12'd1066, 12'd3,   12'd38,  12'd1024};
            MODE_1920X1080: t = '{12'd2200, 12'd44,  12'd148, 12'd1920,
                                  12'd1125, 12'd5,   12'd36,  12'd1080};
            MODE_1600X1200: t = '{12'd2160, 12'd192, 12'd304, 12'd1600,
                                  12'd1250, 12'd3,   12'd46,  12'd1200};
            default:        t = '{12'd800,  12'd96,  12'd48,  12'd640,
                                  12'd525,  12'd2,   12'd33,  12'd480};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/vpg_lock_filter.sv
// rtl/vpg_lock_filter.sv - PLL lock synchronizer with stability and timeout counters
module vpg_lock_filter #(
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 1048576
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic lock_async_i,
    input  logic enable_i,
    output logic stable_o,
    output logic timeout_o
);

    localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_STABLE);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(LOCK_TIMEOUT);

    logic              lock_meta_q;
    logic              lock_sync_q;
    logic [STAB_W-1:0] stab_cnt_q;
    logic [STAB_W-1:0] stab_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_d;

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= lock_async_i;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Saturating counters; both restart whenever the sequencer is not waiting for lock
    always_comb begin
        stab_cnt_d = '0;
        tmo_cnt_d  = '0;
        if (enable_i) begin
            if (lock_sync_q) begin
                stab_cnt_d = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + 1'b1;
            end
            tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stab_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            stab_cnt_q <= stab_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign stable_o  = (stab_cnt_q == STAB_MAX);
    assign timeout_o = (tmo_cnt_q == TMO_MAX);

endmodule

// File: rtl/vpg_mode_sequencer.sv
// rtl/vpg_mode_sequencer.sv - applies a requested video mode: hold VPG, retune PLL, wait lock, release
module vpg_mode_sequencer
    import vpg_pkg::*;
#(
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 1048576,
    parameter int unsigned HOLD_CYCLES  = 16
) (
    input  logic                clkin_i,
    input  logic                reset_i,
    input  logic [MODE_W-1:0]   mode_i,
    input  logic                mode_changed_i,
    output logic                pll_reconf_req_o,
    input  logic                pll_reconf_ack_i,
    output logic [2:0]          pll_sel_o,
    input  logic                pll_locked_i,
    output logic                vpg_reset_o,
    output logic [TIMING_W-1:0] h_total_o,
    output logic [TIMING_W-1:0] h_sync_o,
    output logic [TIMING_W-1:0] h_bp_o,
    output logic [TIMING_W-1:0] h_act_o,
    output logic [TIMING_W-1:0] v_total_o,
    output logic [TIMING_W-1:0] v_sync_o,
    output logic [TIMING_W-1:0] v_bp_o,
    output logic [TIMING_W-1:0] v_act_o,
    output logic [MODE_W-1:0]   active_mode_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int unsigned    HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_e              state_q;
    state_e              state_d;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [MODE_W-1:0]   req_mode_q;
    logic [MODE_W-1:0]   req_mode_clamped;
    logic [MODE_W-1:0]   pend_mode_q;
    logic                pending_q;
    logic [MODE_W-1:0]   active_mode_q;
    logic [2:0]          pll_sel_q;
    timing_t             timing_q;
    logic                err_q;
    logic                first_hold;
    logic                lock_stable;
    logic                lock_timeout;
    logic                wait_done;
    logic                reseq;

    vpg_lock_filter #(
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_filter (
        .clk_i        (clkin_i),
        .reset_i      (reset_i),
        .lock_async_i (pll_locked_i),
        .enable_i     (state_q == ST_WAIT_LOCK),
        .stable_o     (lock_stable),
        .timeout_o    (lock_timeout)
    );

    assign first_hold       = (state_q == ST_HOLD) && (hold_cnt_q == '0);
    assign req_mode_clamped = mode_clamp(req_mode_q);
    assign wait_done        = lock_stable || lock_timeout;
    // A request landing in the same cycle as lock completion is still honoured
    assign reseq            = pending_q || mode_changed_i;

    // State register
    always_ff @(posedge clkin_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (mode_changed_i) state_d = ST_HOLD;
            ST_HOLD:      if (hold_cnt_q == HOLD_LAST) state_d = ST_REQ;
            ST_REQ:       if (pll_reconf_ack_i) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (wait_done) state_d = reseq ? ST_HOLD : ST_RUN;
            ST_RUN:       if (mode_changed_i) state_d = ST_HOLD;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output decode: the generator is released only in RUN
    always_comb begin
        vpg_reset_o      = (state_q != ST_RUN);
        busy_o           = (state_q != ST_RUN);
        pll_reconf_req_o = (state_q == ST_REQ);
    end

    // HOLD dwell counter, restarted on every entry into HOLD
    always_ff @(posedge clkin_i) begin
        if (reset_i) begin
            hold_cnt_q <= '0;
        end else if ((state_q == ST_HOLD) && (state_d == ST_HOLD)) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end else begin
            hold_cnt_q <= '0;
        end
    end

    // Capture the mode to apply; requests mid-sequence are parked, latest wins
    always_ff @(posedge clkin_i) begin
        if (reset_i) begin
            req_mode_q  <= MODE_640X480;
            pend_mode_q <= MODE_640X480;
            pending_q   <= 1'b0;
        end else begin
            if (mode_changed_i) begin
                if ((state_q == ST_IDLE) || (state_q == ST_RUN)) begin
                    req_mode_q <= mode_i;
                end else begin
                    pend_mode_q <= mode_i;
                    pending_q   <= 1'b1;
                end
            end
            if ((state_q == ST_WAIT_LOCK) && (state_d == ST_HOLD)) begin
                req_mode_q <= mode_changed_i ? mode_i : pend_mode_q;
                pending_q  <= 1'b0;
            end
        end
    end

    // Applied configuration and error flag; timing only changes in the first HOLD cycle
    always_ff @(posedge clkin_i) begin
        if (reset_i) begin
            active_mode_q <= MODE_640X480;
            pll_sel_q     <= 3'd0;
            timing_q      <= mode_timing(MODE_640X480);
            err_q         <= 1'b0;
        end else if (first_hold) begin
            active_mode_q <= req_mode_clamped;
            pll_sel_q     <= req_mode_clamped[2:0];
            timing_q      <= mode_timing(req_mode_clamped);
            err_q         <= !mode_is_valid(req_mode_q);
        end else if ((state_q == ST_WAIT_LOCK) && lock_timeout && !lock_stable) begin
            err_q <= 1'b1;
        end
    end

    assign pll_sel_o     = pll_sel_q;
    assign active_mode_o = active_mode_q;
    assign err_o         = err_q;
    assign h_total_o     = timing_q.h_total;
    assign h_sync_o      = timing_q.h_sync;
    assign h_bp_o        = timing_q.h_bp;
    assign h_act_o       = timing_q.h_act;
    assign v_total_o     = timing_q.v_total;
    assign v_sync_o      = timing_q.v_sync;
    assign v_bp_o        = timing_q.v_bp;
    assign v_act_o       = timing_q.v_act;

endmodule

// File: tb/tb_vpg_mode_sequencer.sv
// tb/tb_vpg_mode_sequencer.sv - directed self-checking bench for vpg_mode_sequencer
module tb_vpg_mode_sequencer;
    import vpg_pkg::*;

    localparam int LOCK_STABLE  = 1024;
    localparam int LOCK_TIMEOUT = 4096;
    localparam int HOLD_CYCLES  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mode;
    logic        mode_changed;
    logic        req;
    logic        ack;
    logic [2:0]  pll_sel;
    logic        lock;
    logic        vpg_reset;
    logic [11:0] h_total, h_sync, h_bp, h_act, v_total, v_sync, v_bp, v_act;
    logic [3:0]  active_mode;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vpg_mode_sequencer #(
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .HOLD_CYCLES  (HOLD_CYCLES)
    ) dut (
        .clkin_i          (clk),
        .reset_i          (reset),
        .mode_i           (mode),
        .mode_changed_i   (mode_changed),
        .pll_reconf_req_o (req),
        .pll_reconf_ack_i (ack),
        .pll_sel_o        (pll_sel),
        .pll_locked_i     (lock),
        .vpg_reset_o      (vpg_reset),
        .h_total_o        (h_total),
        .h_sync_o         (h_sync),
        .h_bp_o           (h_bp),
        .h_act_o          (h_act),
        .v_total_o        (v_total),
        .v_sync_o         (v_sync),
        .v_bp_o           (v_bp),
        .v_act_o          (v_act),
        .active_mode_o    (active_mode),
        .busy_o           (busy),
        .err_o            (err)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_mode(input logic [3:0] code);
        mode         = code;
        mode_changed = 1'b1;
        @(negedge clk);
        mode_changed = 1'b0;
        mode         = 4'hF;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!req && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_req_seen"}, int'(req), 1);
    endtask

    task automatic ack_req(input int delay);
        repeat (delay) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic wait_run(input string tag, input int budget, output int n);
        n = 0;
        while (vpg_reset && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_run_seen"}, int'(!vpg_reset), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int held;
        int lows;
        int cnt;

        reset = 1'b1; mode = 4'd0; mode_changed = 1'b0; ack = 1'b0; lock = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check_eq("rst_vpg_reset", int'(vpg_reset), 1);
        check_eq("rst_req", int'(req), 0);
        check_eq("rst_busy", int'(busy), 1);
        check_eq("rst_err", int'(err), 0);
        check_eq("rst_active", int'(active_mode), 0);
        check_eq("rst_pll_sel", int'(pll_sel), 0);
        check_eq("rst_h_total", int'(h_total), 800);
        check_eq("rst_v_total", int'(v_total), 525);
        check_eq("rst_state", int'(dut.state_q), int'(ST_IDLE));

        // Mode 4 full sequence
        pulse_mode(4'd4);
        check_eq("t1_state_hold", int'(dut.state_q), int'(ST_HOLD));
        check_eq("t1_h_total_pre", int'(h_total), 800);
        @(negedge clk);
        check_eq("t1_h_total", int'(h_total), 2200);
        check_eq("t1_h_sync", int'(h_sync), 44);
        check_eq("t1_v_act", int'(v_act), 1080);
        check_eq("t1_pll_sel", int'(pll_sel), 4);
        check_eq("t1_active", int'(active_mode), 4);
        held = 2;
        while (!req && held < 100) begin
            @(negedge clk);
            held++;
        end
        check_eq("t1_hold_cycles", held - 1, HOLD_CYCLES);
        repeat (5) @(negedge clk);
        check_eq("t1_req_held", int'(req), 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_eq("t1_req_drop", int'(req), 0);
        check_eq("t1_state_wait", int'(dut.state_q), int'(ST_WAIT_LOCK));
        lock = 1'b1;
        wait_run("t1", 5000, n);
        check_eq("t1_lock_latency", n, LOCK_STABLE + 3);
        check_eq("t1_err", int'(err), 0);
        check_eq("t1_busy", int'(busy), 0);
        check_eq("t1_v_total_run", int'(v_total), 1125);

        // Mode 2 from RUN, then two requests parked during WAIT_LOCK
        pulse_mode(4'd2);
        check_eq("t2_vpg_reset", int'(vpg_reset), 1);
        check_eq("t2_h_total_pre", int'(h_total), 2200);
        @(negedge clk);
        check_eq("t2_h_total", int'(h_total), 1344);
        check_eq("t2_v_bp", int'(v_bp), 29);
        wait_req("t2");
        ack_req(1);
        repeat (100) @(negedge clk);
        pulse_mode(4'd1);
        repeat (100) @(negedge clk);
        pulse_mode(4'd5);
        check_eq("t2_pending", int'(dut.pending_q), 1);
        n = 0; lows = 0;
        while (dut.state_q != ST_HOLD && n < 2000) begin
            @(negedge clk);
            n++;
            if (!vpg_reset) lows++;
        end
        check_eq("t2_rehold", int'(dut.state_q), int'(ST_HOLD));
        check_eq("t2_no_run_cycle", lows, 0);
        check_eq("t2_pending_clr", int'(dut.pending_q), 0);
        @(negedge clk);
        check_eq("t2_active", int'(active_mode), 5);
        check_eq("t2_h_act", int'(h_act), 1600);
        check_eq("t2_pll_sel", int'(pll_sel), 5);
        wait_req("t2b");
        ack_req(2);
        wait_run("t2", 3000, n);
        check_eq("t2_lock_latency", n, LOCK_STABLE + 1);

        // Invalid code, then a valid code clears ERR
        pulse_mode(4'd9);
        @(negedge clk);
        check_eq("t3_active", int'(active_mode), 0);
        check_eq("t3_h_total", int'(h_total), 800);
        check_eq("t3_pll_sel", int'(pll_sel), 0);
        check_eq("t3_err", int'(err), 1);
        wait_req("t3");
        ack_req(3);
        wait_run("t3", 3000, n);
        check_eq("t3_err_run", int'(err), 1);
        pulse_mode(4'd3);
        @(negedge clk);
        check_eq("t3_err_clr", int'(err), 0);
        check_eq("t3_h_total_m3", int'(h_total), 1688);
        check_eq("t3_v_total_m3", int'(v_total), 1066);
        wait_req("t3b");
        ack_req(1);
        wait_run("t3b", 3000, n);

        // Lock glitches low every 500 cycles until the timeout fires
        pulse_mode(4'd0);
        wait_req("t4");
        ack = 1'b1;
        cnt = 0;
        while (vpg_reset && cnt < 6000) begin
            @(negedge clk);
            cnt++;
            ack = 1'b0;
            if (cnt == 520) check_eq("t4_stab_restart", int'(dut.u_lock_filter.stab_cnt_q), 8);
            lock = ((cnt % 500) >= 10);
        end
        lock = 1'b1;
        check_eq("t4_timeout_latency", cnt, LOCK_TIMEOUT + 2);
        check_eq("t4_err", int'(err), 1);
        check_eq("t4_busy", int'(busy), 0);

        // Reset while requesting, before ACK
        pulse_mode(4'd4);
        wait_req("t5");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("t5_req", int'(req), 0);
        check_eq("t5_vpg_reset", int'(vpg_reset), 1);
        check_eq("t5_state", int'(dut.state_q), int'(ST_IDLE));
        check_eq("t5_h_total", int'(h_total), 800);
        check_eq("t5_v_act", int'(v_act), 480);
        check_eq("t5_active", int'(active_mode), 0);
        check_eq("t5_err", int'(err), 0);

        // ACK with no outstanding request
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        check_eq("t6_state", int'(dut.state_q), int'(ST_IDLE));
        check_eq("t6_req", int'(req), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
